// File: rtl/pattern_sequencer.sv
// Test-pattern sequencer: selects the active pattern and advances it only at frame
// boundaries, either on a latched key request or automatically every AUTO_FRAMES frames.
module pattern_sequencer #(
  parameter int NUM_PATTERNS = 3,
  parameter int AUTO_FRAMES  = 120
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       KEY_PULSE,
  input  logic       AUTO_EN,
  input  logic       FRAME_END,
  output logic [1:0] MODE,
  output logic       MODE_CHG,
  output logic       PENDING,
  output logic [7:0] FRAME_CNT
);

  localparam logic [1:0] LAST_MODE  = 2'(NUM_PATTERNS - 1);
  localparam logic [7:0] LAST_FRAME = 8'(AUTO_FRAMES - 1);
  localparam logic [7:0] CNT_MAX    = 8'd255;

  typedef enum logic {
    SHOW,
    ARMED
  } state_t;

  state_t     state, state_next;
  logic       key_hit, auto_hit, advance;
  logic [1:0] mode_next;
  logic [7:0] cnt_next;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= SHOW;
      MODE      <= '0;
      MODE_CHG  <= 1'b0;
      PENDING   <= 1'b0;
      FRAME_CNT <= '0;
    end else begin
      state     <= state_next;
      MODE      <= mode_next;
      MODE_CHG  <= advance;
      PENDING   <= (state_next == ARMED);
      FRAME_CNT <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    mode_next  = MODE;
    cnt_next   = FRAME_CNT;

    key_hit  = (state == ARMED) && FRAME_END;
    // >= so that re-enabling auto mode after a long disabled stretch advances at once
    auto_hit = AUTO_EN && FRAME_END && (FRAME_CNT >= LAST_FRAME);
    advance  = key_hit || auto_hit;

    case (state)
      SHOW:    if (KEY_PULSE) state_next = ARMED;
      ARMED:   if (FRAME_END) state_next = KEY_PULSE ? ARMED : SHOW;
      default: state_next = SHOW;
    endcase

    if (advance) begin
      mode_next = (MODE == LAST_MODE) ? '0 : MODE + 2'd1;
      cnt_next  = '0;
    end else if (FRAME_END && (FRAME_CNT != CNT_MAX)) begin
      cnt_next = FRAME_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with NUM_PATTERNS=3, AUTO_FRAMES=4.
module tb_pattern_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       KEY_PULSE = 1'b0;
  logic       AUTO_EN = 1'b0;
  logic       FRAME_END = 1'b0;
  logic [1:0] MODE;
  logic       MODE_CHG;
  logic       PENDING;
  logic [7:0] FRAME_CNT;

  int checks = 0;
  int errors = 0;

  pattern_sequencer #(.NUM_PATTERNS(3), .AUTO_FRAMES(4)) dut (
    .CLK(CLK), .RESET(RESET), .KEY_PULSE(KEY_PULSE), .AUTO_EN(AUTO_EN),
    .FRAME_END(FRAME_END), .MODE(MODE), .MODE_CHG(MODE_CHG),
    .PENDING(PENDING), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  // Advance one cycle; return 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    KEY_PULSE = 1'b0; FRAME_END = 1'b0; AUTO_EN = 1'b0;
    RESET = 1'b1;
    #3;
    RESET = 1'b0;
  endtask

  task automatic drive(input logic key, input logic fe);
    KEY_PULSE = key; FRAME_END = fe;
    tick();
    KEY_PULSE = 1'b0; FRAME_END = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #3;
    checks++;
    if ({MODE, MODE_CHG, PENDING, FRAME_CNT} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got mode=%0d chg=%0b pend=%0b cnt=%0d expected all 0",
               MODE, MODE_CHG, PENDING, FRAME_CNT);
    end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_key_latency();
    do_reset();
    idle(9);
    drive(1'b1, 1'b0);                 // key at cycle 10
    for (int c = 11; c <= 49; c++) begin
      checks++;
      if (PENDING !== 1'b1 || MODE !== 2'd0 || MODE_CHG !== 1'b0) begin
        errors++;
        $display("FAIL key_wait c%0d: got pend=%0b mode=%0d chg=%0b expected 1 0 0",
                 c, PENDING, MODE, MODE_CHG);
      end
      tick();
    end
    checks++;
    if (PENDING !== 1'b1) begin
      errors++; $display("FAIL key_wait c50: got pend=%0b expected 1", PENDING);
    end
    drive(1'b0, 1'b1);                 // frame end at cycle 50
    checks++;
    if (MODE !== 2'd1 || MODE_CHG !== 1'b1 || PENDING !== 1'b0 || FRAME_CNT !== 8'd0) begin
      errors++;
      $display("FAIL key_advance: got mode=%0d chg=%0b pend=%0b cnt=%0d expected 1 1 0 0",
               MODE, MODE_CHG, PENDING, FRAME_CNT);
    end
    tick();
    checks++;
    if (MODE_CHG !== 1'b0 || MODE !== 2'd1) begin
      errors++; $display("FAIL key_chg_once: got chg=%0b mode=%0d expected 0 1", MODE_CHG, MODE);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_mode [3] = '{2'd1, 2'd2, 2'd0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0);
      idle(3);
      drive(1'b0, 1'b1);
      checks++;
      if (MODE !== exp_mode[i] || MODE_CHG !== 1'b1) begin
        errors++;
        $display("FAIL wrap_%0d: got mode=%0d chg=%0b expected %0d 1", i, MODE, MODE_CHG, exp_mode[i]);
      end
      idle(2);
    end
  endtask

  task automatic test_same_cycle_show();
    do_reset();
    idle(2);
    drive(1'b1, 1'b1);
    checks++;
    if (MODE !== 2'd0 || MODE_CHG !== 1'b0 || PENDING !== 1'b1 || FRAME_CNT !== 8'd1) begin
      errors++;
      $display("FAIL show_key_fe: got mode=%0d chg=%0b pend=%0b cnt=%0d expected 0 0 1 1",
               MODE, MODE_CHG, PENDING, FRAME_CNT);
    end
    idle(4);
    drive(1'b0, 1'b1);
    checks++;
    if (MODE !== 2'd1 || MODE_CHG !== 1'b1 || PENDING !== 1'b0 || FRAME_CNT !== 8'd0) begin
      errors++;
      $display("FAIL show_next_fe: got mode=%0d chg=%0b pend=%0b cnt=%0d expected 1 1 0 0",
               MODE, MODE_CHG, PENDING, FRAME_CNT);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);                 // second key while armed: ignored
    drive(1'b1, 1'b1);                 // key + frame end while armed
    checks++;
    if (MODE !== 2'd1 || MODE_CHG !== 1'b1 || PENDING !== 1'b1) begin
      errors++;
      $display("FAIL armed_key_fe: got mode=%0d chg=%0b pend=%0b expected 1 1 1", MODE, MODE_CHG, PENDING);
    end
    drive(1'b0, 1'b1);
    checks++;
    if (MODE !== 2'd2 || MODE_CHG !== 1'b1 || PENDING !== 1'b0) begin
      errors++;
      $display("FAIL armed_follow: got mode=%0d chg=%0b pend=%0b expected 2 1 0", MODE, MODE_CHG, PENDING);
    end
    drive(1'b0, 1'b1);
    checks++;
    if (MODE !== 2'd2 || MODE_CHG !== 1'b0 || FRAME_CNT !== 8'd1) begin
      errors++;
      $display("FAIL one_per_boundary: got mode=%0d chg=%0b cnt=%0d expected 2 0 1", MODE, MODE_CHG, FRAME_CNT);
    end
  endtask

  task automatic test_auto();
    logic [7:0] exp_cnt  [12] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    logic [1:0] exp_mode [12] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    logic       exp_chg  [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    AUTO_EN = 1'b1;
    for (int i = 0; i < 12; i++) begin
      idle(3);
      drive(1'b0, 1'b1);
      checks++;
      if (FRAME_CNT !== exp_cnt[i] || MODE !== exp_mode[i] || MODE_CHG !== exp_chg[i]) begin
        errors++;
        $display("FAIL auto_fe%0d: got cnt=%0d mode=%0d chg=%0b expected %0d %0d %0b",
                 i + 1, FRAME_CNT, MODE, MODE_CHG, exp_cnt[i], exp_mode[i], exp_chg[i]);
      end
    end
    AUTO_EN = 1'b0;
  endtask

  task automatic test_auto_key();
    do_reset();
    AUTO_EN = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);                 // auto and key coincide while armed
    checks++;
    if (MODE !== 2'd1 || MODE_CHG !== 1'b1 || PENDING !== 1'b0 || FRAME_CNT !== 8'd0) begin
      errors++;
      $display("FAIL auto_key_armed: got mode=%0d chg=%0b pend=%0b cnt=%0d expected 1 1 0 0",
               MODE, MODE_CHG, PENDING, FRAME_CNT);
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);                 // auto advance in SHOW with a key in the same cycle
    checks++;
    if (MODE !== 2'd2 || MODE_CHG !== 1'b1 || PENDING !== 1'b1 || FRAME_CNT !== 8'd0) begin
      errors++;
      $display("FAIL auto_key_show: got mode=%0d chg=%0b pend=%0b cnt=%0d expected 2 1 1 0",
               MODE, MODE_CHG, PENDING, FRAME_CNT);
    end
    AUTO_EN = 1'b0;
  endtask

  task automatic test_auto_disable();
    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1);
    checks++;
    if (MODE !== 2'd0 || FRAME_CNT !== 8'd6) begin
      errors++;
      $display("FAIL auto_off: got mode=%0d cnt=%0d expected 0 6", MODE, FRAME_CNT);
    end
    AUTO_EN = 1'b1;
    idle(2);
    checks++;
    if (MODE !== 2'd0 || MODE_CHG !== 1'b0) begin
      errors++;
      $display("FAIL auto_reenable_midframe: got mode=%0d chg=%0b expected 0 0", MODE, MODE_CHG);
    end
    drive(1'b0, 1'b1);
    checks++;
    if (MODE !== 2'd1 || MODE_CHG !== 1'b1 || FRAME_CNT !== 8'd0) begin
      errors++;
      $display("FAIL auto_reenable: got mode=%0d chg=%0b cnt=%0d expected 1 1 0", MODE, MODE_CHG, FRAME_CNT);
    end
    AUTO_EN = 1'b0;
  endtask

  task automatic test_reset_armed();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
    end
    drive(1'b1, 1'b0);
    checks++;
    if (MODE !== 2'd2 || PENDING !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got mode=%0d pend=%0b expected 2 1", MODE, PENDING);
    end
    RESET = 1'b1;
    #2;                                // no clock edge in between
    checks++;
    if (MODE !== 2'd0 || PENDING !== 1'b0 || MODE_CHG !== 1'b0 || FRAME_CNT !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: got mode=%0d pend=%0b chg=%0b cnt=%0d expected 0 0 0 0",
               MODE, PENDING, MODE_CHG, FRAME_CNT);
    end
    #1 RESET = 1'b0;
    drive(1'b0, 1'b1);
    checks++;
    if (MODE !== 2'd0 || MODE_CHG !== 1'b0 || FRAME_CNT !== 8'd1) begin
      errors++;
      $display("FAIL post_reset_fe: got mode=%0d chg=%0b cnt=%0d expected 0 0 1", MODE, MODE_CHG, FRAME_CNT);
    end
    FRAME_END = 1'b1;
    idle(299);
    FRAME_END = 1'b0;
    checks++;
    if (FRAME_CNT !== 8'd255 || MODE !== 2'd0) begin
      errors++;
      $display("FAIL cnt_saturate: got cnt=%0d mode=%0d expected 255 0", FRAME_CNT, MODE);
    end
  endtask

  initial begin
    test_reset();
    test_key_latency();
    test_wrap();
    test_same_cycle_show();
    test_back_to_back();
    test_auto();
    test_auto_key();
    test_auto_disable();
    test_reset_armed();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter NUM_PATTERNS, default 3, number of test patterns cycled (2..4).
REQ-002 Parameter AUTO_FRAMES, default 120, frames per pattern in auto mode (2..255; 120 = 2 s at 60 Hz).
REQ-003 Port CLK  in  1  pixel clock (148.5 MHz nominal); the single clock of the block.
REQ-004 Port RESET  in  1  reset, asynchronous, active-high.
REQ-005 Port KEY_PULSE  in  1  debounced single-cycle advance request, synchronous to CLK.
REQ-006 Port AUTO_EN  in  1  level; 1 = auto-advance every AUTO_FRAMES frames.
REQ-007 Port FRAME_END  in  1  single-cycle pulse in the last pixel of a frame (CC=2199, LL=1124).
REQ-008 Port MODE  out  2  registered pattern select driving the pattern mux (0, 1, 2 = X, Y, X^Y).
REQ-009 Port MODE_CHG  out  1  registered one-cycle pulse in the cycle MODE takes a new value.
REQ-010 Port PENDING  out  1  registered; 1 = key request latched, awaiting frame boundary.
REQ-011 Port FRAME_CNT  out  8  registered frames since last MODE change, saturating at 255.

Function
REQ-012 MODE shall change only on a clock edge at which FRAME_END=1; MODE never changes mid-frame.
REQ-013 Advance shall set MODE to MODE+1, or to 0 when MODE=NUM_PATTERNS-1; values >=NUM_PATTERNS never occur.
REQ-014 FSM states: SHOW (no request), ARMED (request latched); PENDING=1 exactly in ARMED.
REQ-015 SHOW, KEY_PULSE=1 -> ARMED on that edge; no advance at a FRAME_END coinciding with the key pulse.
REQ-016 ARMED, FRAME_END=1 -> advance, FRAME_CNT:=0, -> SHOW.
REQ-017 ARMED, KEY_PULSE=1 without FRAME_END -> ignored; one advance per boundary maximum.
REQ-018 ARMED, KEY_PULSE=1 and FRAME_END=1 same cycle -> advance once, remain ARMED.
REQ-019 FRAME_CNT shall increment on each FRAME_END without advance, saturating at 255.
REQ-020 AUTO_EN=1, FRAME_END=1, FRAME_CNT=AUTO_FRAMES-1 -> advance, FRAME_CNT:=0, regardless of state.
REQ-021 Auto and key advance at the same FRAME_END (ARMED) shall produce a single advance; state -> SHOW.
REQ-022 Auto advance in SHOW with simultaneous KEY_PULSE: advance once, state -> ARMED.
REQ-023 AUTO_EN=0 shall suppress auto advance; FRAME_CNT keeps counting; re-enabling with FRAME_CNT>=AUTO_FRAMES-1 advances at the next FRAME_END.
REQ-024 MODE_CHG=1 for exactly the cycle after every advancing edge, else 0.
REQ-025 Latency: FRAME_END at cycle n (advance condition met) -> new MODE and MODE_CHG=1 visible in cycle n+1.

Reset
REQ-026 RESET=1 shall immediately force MODE=0, MODE_CHG=0, PENDING=0, FRAME_CNT=0, state SHOW, independent of CLK.
REQ-027 Reset mid-ARMED shall discard the pending request; no advance at the first FRAME_END after release.
REQ-028 First rising CLK edge after RESET falls shall be a normal functional edge.

Verification (AUTO_FRAMES=4, NUM_PATTERNS=3 unless noted)
REQ-029 Reset, AUTO_EN=0, KEY_PULSE at cycle 10, FRAME_END at 50 -> PENDING=1 cycles 11..50; MODE 0->1 and MODE_CHG=1 at cycle 51 only.
REQ-030 Three key presses each followed by FRAME_END -> MODE 0,1,2,0; never 3.
REQ-031 KEY_PULSE and FRAME_END same cycle in SHOW -> no change then; MODE advances at the following FRAME_END.
REQ-032 AUTO_EN=1, 12 FRAME_ENDs -> MODE changes after 4th, 8th, 12th (1,2,0); FRAME_CNT sequence 1,2,3,0 repeating.
REQ-033 AUTO_EN=1, key at FRAME_CNT=3, FRAME_END -> single advance, PENDING=0, FRAME_CNT=0.
REQ-034 RESET pulse while ARMED, MODE=2 -> MODE=0, PENDING=0 asynchronously; next FRAME_END no MODE_CHG; 300 FRAME_ENDs, AUTO_EN=0 -> FRAME_CNT=255.
